// File: rtl/sal_mbk_ctrl.sv
// Multi-bank DRAM command controller: per-bank open/row state and timing, shared
// inter-bank timing, all-bank refresh, open-page (idle timeout) or close-page policy.
module sal_mbk_ctrl #(
   parameter int NUM_BANKS  = 4,
   parameter int BA_WIDTH   = 2,
   parameter int RA_WIDTH   = 16,
   parameter int CA_WIDTH   = 10,
   parameter int ID_WIDTH   = 4,
   parameter int LEN_WIDTH  = 4,
   parameter int CNTR_WIDTH = 8,
   parameter int CLOSE_PAGE = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CNTR_WIDTH-1:0] t_rc_m1,
   input  logic [CNTR_WIDTH-1:0] t_rcd_m1,
   input  logic [CNTR_WIDTH-1:0] t_rp_m1,
   input  logic [CNTR_WIDTH-1:0] t_ras_m1,
   input  logic [CNTR_WIDTH-1:0] t_rfc_m1,
   input  logic [CNTR_WIDTH-1:0] t_rtp_m1,
   input  logic [CNTR_WIDTH-1:0] t_wtp_m1,
   input  logic [CNTR_WIDTH-1:0] t_rrd_m1,
   input  logic [CNTR_WIDTH-1:0] t_ccd_m1,
   input  logic [CNTR_WIDTH-1:0] t_rtw_m1,
   input  logic [CNTR_WIDTH-1:0] t_wtr_m1,
   input  logic [CNTR_WIDTH-1:0] row_open_cnt,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_wr,
   input  logic [BA_WIDTH-1:0]   req_ba,
   input  logic [RA_WIDTH-1:0]   req_ra,
   input  logic [CA_WIDTH-1:0]   req_ca,
   input  logic [ID_WIDTH-1:0]   req_id,
   input  logic [LEN_WIDTH-1:0]  req_len,
   input  logic                  ref_req_i,
   output logic                  ref_gnt_o,
   output logic                  cmd_valid,
   output logic [2:0]            cmd_type,
   output logic [BA_WIDTH-1:0]   cmd_ba,
   output logic [RA_WIDTH-1:0]   cmd_ra,
   output logic [CA_WIDTH-1:0]   cmd_ca,
   output logic [ID_WIDTH-1:0]   cmd_id,
   output logic [LEN_WIDTH-1:0]  cmd_len,
   output logic [NUM_BANKS-1:0]  bank_open_o
);
   localparam logic [2:0] CMD_ACT = 3'd0, CMD_RD = 3'd1, CMD_WR = 3'd2, CMD_PRE = 3'd3, CMD_REF = 3'd4;

   typedef logic [CNTR_WIDTH-1:0] cnt_t;

   function automatic cnt_t f_dec(input cnt_t c);
      return (c == '0) ? c : c - cnt_t'(1);
   endfunction

   function automatic logic [BA_WIDTH-1:0] f_rr(input logic [BA_WIDTH-1:0] p, input int i);
      return BA_WIDTH'((int'(p) + i) % NUM_BANKS);
   endfunction

   logic [NUM_BANKS-1:0]                 r_open;
   logic [NUM_BANKS-1:0][RA_WIDTH-1:0]   r_cur_ra;
   logic [NUM_BANKS-1:0][CNTR_WIDTH-1:0] r_rc, r_rcd, r_ras, r_rp, r_rtp, r_wtp, r_ropen;
   cnt_t                                 r_rrd, r_ccd, r_rtw, r_wtr, r_rfc;
   logic [BA_WIDTH-1:0]                  r_rr_ptr;

   logic [NUM_BANKS-1:0] w_act_ok, w_pre_ok, w_idle_ok;
   logic                 w_hit, w_found;
   logic                 w_cmd_valid, w_req_ready, w_ref_gnt, w_idle_gnt;
   logic [2:0]           w_cmd_type;
   logic [BA_WIDTH-1:0]  w_cmd_ba;
   logic                 w_act, w_rd, w_wr, w_pre, w_ref;

   assign w_hit = r_open[req_ba] && (r_cur_ra[req_ba] == req_ra);

   for (genvar g = 0; g < NUM_BANKS; g++) begin : g_met
      assign w_act_ok[g]  = (r_rc[g] == '0) && (r_rp[g] == '0);
      assign w_pre_ok[g]  = r_open[g] && (r_ras[g] == '0) && (r_rtp[g] == '0) && (r_wtp[g] == '0);
      // a bank with a waiting row hit must stay open for it
      assign w_idle_ok[g] = w_pre_ok[g] && ((CLOSE_PAGE != 0) || (r_ropen[g] == '0)) &&
                            !(req_valid && w_hit && (req_ba == BA_WIDTH'(g)));
   end

   always_comb begin
      w_cmd_valid = 1'b0;
      w_cmd_type  = CMD_ACT;
      w_cmd_ba    = '0;
      w_req_ready = 1'b0;
      w_ref_gnt   = 1'b0;
      w_idle_gnt  = 1'b0;
      w_found     = 1'b0;
      if (ref_req_i) begin
         for (int i = 0; i < NUM_BANKS; i++) begin
            if (!w_found && w_pre_ok[i]) begin
               w_found     = 1'b1;
               w_cmd_valid = 1'b1;
               w_cmd_type  = CMD_PRE;
               w_cmd_ba    = BA_WIDTH'(i);
            end
         end
         if ((r_open == '0) && (&w_act_ok) && (r_rfc == '0)) begin
            w_cmd_valid = 1'b1;
            w_cmd_type  = CMD_REF;
            w_ref_gnt   = 1'b1;
         end
      end else begin
         if (req_valid) begin
            w_cmd_ba = req_ba;
            if (!r_open[req_ba]) begin
               if (w_act_ok[req_ba] && (r_rfc == '0) && (r_rrd == '0)) begin
                  w_cmd_valid = 1'b1;
                  w_cmd_type  = CMD_ACT;
               end
            end else if (w_hit) begin
               if ((r_rcd[req_ba] == '0) && (r_ccd == '0) && (req_wr ? (r_rtw == '0) : (r_wtr == '0))) begin
                  w_cmd_valid = 1'b1;
                  w_cmd_type  = req_wr ? CMD_WR : CMD_RD;
                  w_req_ready = 1'b1;
               end
            end else if (w_pre_ok[req_ba]) begin
               w_cmd_valid = 1'b1;
               w_cmd_type  = CMD_PRE;
            end
         end
         if (!w_cmd_valid) begin
            w_cmd_ba = '0;
            for (int i = 0; i < NUM_BANKS; i++) begin
               if (!w_found && w_idle_ok[f_rr(r_rr_ptr, i)]) begin
                  w_found     = 1'b1;
                  w_cmd_valid = 1'b1;
                  w_cmd_type  = CMD_PRE;
                  w_cmd_ba    = f_rr(r_rr_ptr, i);
                  w_idle_gnt  = 1'b1;
               end
            end
         end
      end
   end

   assign w_act = w_cmd_valid && (w_cmd_type == CMD_ACT);
   assign w_rd  = w_cmd_valid && (w_cmd_type == CMD_RD);
   assign w_wr  = w_cmd_valid && (w_cmd_type == CMD_WR);
   assign w_pre = w_cmd_valid && (w_cmd_type == CMD_PRE);
   assign w_ref = w_cmd_valid && (w_cmd_type == CMD_REF);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rrd    <= '0;
         r_ccd    <= '0;
         r_rtw    <= '0;
         r_wtr    <= '0;
         r_rfc    <= '0;
         r_rr_ptr <= '0;
         r_open   <= '0;
         r_cur_ra <= '0;
         r_rc     <= '0;
         r_rcd    <= '0;
         r_ras    <= '0;
         r_rp     <= '0;
         r_rtp    <= '0;
         r_wtp    <= '0;
         r_ropen  <= '0;
      end else begin
         r_rrd <= w_act ? t_rrd_m1 : f_dec(r_rrd);
         r_ccd <= (w_rd || w_wr) ? t_ccd_m1 : f_dec(r_ccd);
         r_rtw <= w_rd ? t_rtw_m1 : f_dec(r_rtw);
         r_wtr <= w_wr ? t_wtr_m1 : f_dec(r_wtr);
         r_rfc <= w_ref ? t_rfc_m1 : f_dec(r_rfc);
         if (w_idle_gnt)
            r_rr_ptr <= (w_cmd_ba == BA_WIDTH'(NUM_BANKS-1)) ? '0 : w_cmd_ba + BA_WIDTH'(1);
         for (int i = 0; i < NUM_BANKS; i++) begin
            r_rc[i]    <= (w_act && (w_cmd_ba == BA_WIDTH'(i))) ? t_rc_m1  : f_dec(r_rc[i]);
            r_rcd[i]   <= (w_act && (w_cmd_ba == BA_WIDTH'(i))) ? t_rcd_m1 : f_dec(r_rcd[i]);
            r_ras[i]   <= (w_act && (w_cmd_ba == BA_WIDTH'(i))) ? t_ras_m1 : f_dec(r_ras[i]);
            r_rp[i]    <= (w_pre && (w_cmd_ba == BA_WIDTH'(i))) ? t_rp_m1  : f_dec(r_rp[i]);
            r_rtp[i]   <= (w_rd  && (w_cmd_ba == BA_WIDTH'(i))) ? t_rtp_m1 : f_dec(r_rtp[i]);
            r_wtp[i]   <= (w_wr  && (w_cmd_ba == BA_WIDTH'(i))) ? t_wtp_m1 : f_dec(r_wtp[i]);
            r_ropen[i] <= ((w_rd || w_wr) && (w_cmd_ba == BA_WIDTH'(i))) ? row_open_cnt : f_dec(r_ropen[i]);
            if (w_act && (w_cmd_ba == BA_WIDTH'(i))) begin
               r_open[i]   <= 1'b1;
               r_cur_ra[i] <= req_ra;
            end else if (w_pre && (w_cmd_ba == BA_WIDTH'(i))) begin
               r_open[i] <= 1'b0;
            end
         end
      end
   end

   // outputs are forced low for the whole time rst is high, not just after the edge
   assign cmd_valid   = w_cmd_valid && !rst;
   assign cmd_type    = rst ? 3'd0 : w_cmd_type;
   assign cmd_ba      = rst ? '0 : w_cmd_ba;
   assign cmd_ra      = (!rst && w_act) ? req_ra : '0;
   assign cmd_ca      = (!rst && w_req_ready) ? req_ca : '0;
   assign cmd_id      = (!rst && w_req_ready) ? req_id : '0;
   assign cmd_len     = (!rst && w_req_ready) ? req_len : '0;
   assign req_ready   = w_req_ready && !rst;
   assign ref_gnt_o   = w_ref_gnt && !rst;
   assign bank_open_o = r_open;

endmodule
